// File: rtl/uart_tx_buffered.sv
// -----------------------------------------------------------------------------
// uart_tx_buffered
//
// UART transmitter with an internal TX FIFO, a runtime frame format and a
// runtime baud divisor. It sits between the UART CSR block and the serial pin.
//
// Frame format (chosen per frame): start bit, 5..DATA_W data bits (LSB first),
// optional even/odd parity bit, then 1 or 2 stop bits. Frames are sent back to
// back with no idle cycle between the last stop bit and the next start bit.
//
// Parameters
//   FIFO_DEPTH : TX FIFO entries (power of 2, >= 2)
//   DATA_W     : maximum data bits per frame, width of wr_data (<= 15)
//   DIV_W      : baud divisor width
//
// Ports
//   clk            : clock
//   rst_n          : synchronous active-low reset
//   cfg_baud_div   : bit period is cfg_baud_div+1 clock cycles
//   cfg_data_bits  : data bits per frame; clamped into 5..DATA_W at frame start
//   cfg_parity_en  : 1 = append a parity bit
//   cfg_parity_odd : 1 = odd parity, 0 = even parity
//   cfg_stop2      : 1 = two stop bits
//   tx_en          : 1 = allow FIFO pops / new frames
//   wr_valid       : write request into the FIFO
//   wr_data        : frame payload, LSB sent first
//   wr_ready       : FIFO not full
//   fifo_count     : occupied FIFO entries
//   txd            : serial line, idle high, registered
//   busy           : 1 whenever the frame FSM is not idle
//   tx_done        : one-cycle pulse during the final cycle of the last stop bit
// -----------------------------------------------------------------------------
module uart_tx_buffered #(
    parameter int FIFO_DEPTH = 8,
    parameter int DATA_W     = 9,
    parameter int DIV_W      = 16
) (
    input  logic                                clk,
    input  logic                                rst_n,
    input  logic [DIV_W-1:0]                    cfg_baud_div,
    input  logic [3:0]                          cfg_data_bits,
    input  logic                                cfg_parity_en,
    input  logic                                cfg_parity_odd,
    input  logic                                cfg_stop2,
    input  logic                                tx_en,
    input  logic                                wr_valid,
    input  logic [DATA_W-1:0]                   wr_data,
    output logic                                wr_ready,
    output logic [$clog2(FIFO_DEPTH+1)-1:0]     fifo_count,
    output logic                                txd,
    output logic                                busy,
    output logic                                tx_done
);

    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam int CNT_W = $clog2(FIFO_DEPTH + 1);

    // -------------------------------------------------------------------------
    // TX FIFO
    // -------------------------------------------------------------------------
    logic [DATA_W-1:0] fifo_mem [FIFO_DEPTH];
    logic [PTR_W-1:0]  wr_ptr_reg;
    logic [PTR_W-1:0]  rd_ptr_reg;
    logic [CNT_W-1:0]  count_reg;

    logic              fifo_full;
    logic              fifo_empty;
    logic              push;
    logic              pop;
    logic [DATA_W-1:0] head_data;

    assign fifo_full  = (count_reg == CNT_W'(FIFO_DEPTH));
    assign fifo_empty = (count_reg == '0);

    // Ready depends on the occupancy only: a pop on the same edge does not
    // open a slot for a concurrent write.
    assign push = wr_valid && !fifo_full;

    // The head word is consumed directly on the pop edge, so the read is
    // asynchronous from the small storage array.
    assign head_data = fifo_mem[rd_ptr_reg];

    always_ff @(posedge clk) begin
        if (rst_n && push) begin
            fifo_mem[wr_ptr_reg] <= wr_data;
        end
    end

    // Pointers wrap naturally because FIFO_DEPTH is a power of two.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
            count_reg  <= '0;
        end else begin
            if (push) begin
                wr_ptr_reg <= wr_ptr_reg + PTR_W'(1);
            end
            if (pop) begin
                rd_ptr_reg <= rd_ptr_reg + PTR_W'(1);
            end
            case ({push, pop})
                2'b10:   count_reg <= count_reg + CNT_W'(1);
                2'b01:   count_reg <= count_reg - CNT_W'(1);
                default: count_reg <= count_reg;
            endcase
        end
    end

    // -------------------------------------------------------------------------
    // Frame set-up values derived from the FIFO head and the live config.
    // They are only captured on a pop edge.
    // -------------------------------------------------------------------------
    logic [3:0]        bits_clamped;
    logic [DATA_W-1:0] head_masked;
    logic              head_parity;

    always_comb begin
        bits_clamped = cfg_data_bits;
        if (cfg_data_bits < 4'd5) begin
            bits_clamped = 4'd5;
        end else if (cfg_data_bits > 4'(DATA_W)) begin
            bits_clamped = 4'(DATA_W);
        end
    end

    // Payload bits above the configured width take no part in the parity.
    for (genvar gi = 0; gi < DATA_W; gi++) begin : g_mask
        assign head_masked[gi] = head_data[gi] & (4'(gi) < bits_clamped);
    end

    assign head_parity = (^head_masked) ^ cfg_parity_odd;

    // -------------------------------------------------------------------------
    // Frame FSM
    // -------------------------------------------------------------------------
    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_DATA,
        S_PARITY,
        S_STOP
    } state_t;

    state_t            state_reg;
    logic [DIV_W-1:0]  cnt_reg;        // cycles left in the current bit
    logic [DIV_W-1:0]  div_reg;        // latched divisor for this frame
    logic [DATA_W-1:0] shift_reg;      // remaining data bits, LSB next
    logic [3:0]        bits_reg;       // latched data bit count
    logic [3:0]        bit_idx_reg;    // index of the data bit on the line
    logic              parity_en_reg;
    logic              parity_bit_reg;
    logic              stop2_reg;
    logic              stop_idx_reg;   // 0 = first stop bit, 1 = second
    logic              txd_reg;
    logic              busy_reg;
    logic              tx_done_reg;

    logic              bit_end;
    logic              last_stop;
    logic              frame_end;

    assign bit_end   = (cnt_reg == '0);
    assign last_stop = !stop2_reg || stop_idx_reg;
    assign frame_end = (state_reg == S_STOP) && bit_end && last_stop;

    // A new frame starts either from idle or straight out of the last stop
    // bit of the previous frame, which gives gap-free back-to-back frames.
    assign pop = tx_en && !fifo_empty && ((state_reg == S_IDLE) || frame_end);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_reg      <= S_IDLE;
            cnt_reg        <= '0;
            div_reg        <= '0;
            shift_reg      <= '0;
            bits_reg       <= 4'd5;
            bit_idx_reg    <= '0;
            parity_en_reg  <= 1'b0;
            parity_bit_reg <= 1'b0;
            stop2_reg      <= 1'b0;
            stop_idx_reg   <= 1'b0;
            txd_reg        <= 1'b1;
            busy_reg       <= 1'b0;
            tx_done_reg    <= 1'b0;
        end else begin
            tx_done_reg <= 1'b0;

            if (pop) begin
                // Capture the word and the whole frame format; mid-frame
                // config changes only affect the next frame.
                state_reg      <= S_START;
                txd_reg        <= 1'b0;
                busy_reg       <= 1'b1;
                cnt_reg        <= cfg_baud_div;
                div_reg        <= cfg_baud_div;
                shift_reg      <= head_data;
                bits_reg       <= bits_clamped;
                bit_idx_reg    <= '0;
                parity_en_reg  <= cfg_parity_en;
                parity_bit_reg <= head_parity;
                stop2_reg      <= cfg_stop2;
                stop_idx_reg   <= 1'b0;
            end else begin
                case (state_reg)
                    S_IDLE: begin
                        txd_reg  <= 1'b1;
                        busy_reg <= 1'b0;
                    end

                    S_START: begin
                        if (bit_end) begin
                            state_reg   <= S_DATA;
                            cnt_reg     <= div_reg;
                            txd_reg     <= shift_reg[0];
                            shift_reg   <= shift_reg >> 1;
                            bit_idx_reg <= '0;
                        end else begin
                            cnt_reg <= cnt_reg - DIV_W'(1);
                        end
                    end

                    S_DATA: begin
                        if (bit_end) begin
                            cnt_reg <= div_reg;
                            if (bit_idx_reg == bits_reg - 4'd1) begin
                                if (parity_en_reg) begin
                                    state_reg <= S_PARITY;
                                    txd_reg   <= parity_bit_reg;
                                end else begin
                                    state_reg    <= S_STOP;
                                    txd_reg      <= 1'b1;
                                    stop_idx_reg <= 1'b0;
                                    // A one-cycle single stop bit is its own final cycle.
                                    tx_done_reg  <= !stop2_reg && (div_reg == '0);
                                end
                            end else begin
                                bit_idx_reg <= bit_idx_reg + 4'd1;
                                txd_reg     <= shift_reg[0];
                                shift_reg   <= shift_reg >> 1;
                            end
                        end else begin
                            cnt_reg <= cnt_reg - DIV_W'(1);
                        end
                    end

                    S_PARITY: begin
                        if (bit_end) begin
                            state_reg    <= S_STOP;
                            cnt_reg      <= div_reg;
                            txd_reg      <= 1'b1;
                            stop_idx_reg <= 1'b0;
                            tx_done_reg  <= !stop2_reg && (div_reg == '0);
                        end else begin
                            cnt_reg <= cnt_reg - DIV_W'(1);
                        end
                    end

                    S_STOP: begin
                        if (bit_end) begin
                            if (last_stop) begin
                                // No word to follow (a follow-on word is handled by pop).
                                state_reg <= S_IDLE;
                                busy_reg  <= 1'b0;
                                txd_reg   <= 1'b1;
                            end else begin
                                stop_idx_reg <= 1'b1;
                                cnt_reg      <= div_reg;
                                tx_done_reg  <= (div_reg == '0);
                            end
                        end else begin
                            cnt_reg <= cnt_reg - DIV_W'(1);
                            // Registered pulse: raise it one edge ahead so it
                            // lines up with the final cycle of the last stop bit.
                            tx_done_reg <= last_stop && (cnt_reg == DIV_W'(1));
                        end
                    end

                    default: begin
                        state_reg <= S_IDLE;
                        txd_reg   <= 1'b1;
                        busy_reg  <= 1'b0;
                    end
                endcase
            end
        end
    end

    // -------------------------------------------------------------------------
    // Outputs
    // -------------------------------------------------------------------------
    assign wr_ready   = !fifo_full;
    assign fifo_count = count_reg;
    assign txd        = txd_reg;
    assign busy       = busy_reg;
    assign tx_done    = tx_done_reg;

endmodule
